// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control slice.
package mips_pipe_pkg;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hilo_busy_counter.sv
// Tracks an in-flight multi-cycle Hi/Lo operation: loaded on issue, counts down,
// and holds busy high for exactly MULDIV_CYCLES cycles after the issue edge.
module hilo_busy_counter
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic load,
  output logic busy
);

  hz_state_t   state;
  logic [3:0]  count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= HZ_IDLE;
      count <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        HZ_IDLE: begin
          if (load) begin
            state <= HZ_BUSY;
            count <= 4'(MULDIV_CYCLES);
            busy  <= 1'b1;
          end
        end
        HZ_BUSY: begin
          // Leaving on count==1 gives MULDIV_CYCLES busy cycles, including the 1-cycle case.
          if (count == 4'd1) begin
            state <= HZ_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= HZ_IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use and Hi/Lo stalls, branch flush, and a
// saturating stall-cycle counter.
module hazard_stall_unit
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   IDEX_MemRead,
  input  logic [4:0]             IDEX_Rt,
  input  logic [4:0]             IFID_Rs,
  input  logic [4:0]             IFID_Rt,
  input  logic                   IFID_UsesRt,
  input  logic                   ID_MulDiv,
  input  logic                   ID_ReadsHiLo,
  input  logic                   EX_BranchTaken,
  output logic                   nop,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IFIDFlush,
  output logic                   HiLoBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic load_use;
  logic hilo_haz;
  logic stall;
  logic issue;

  always_comb begin
    load_use = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
               ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    hilo_haz = (ID_MulDiv || ID_ReadsHiLo) && HiLoBusy;
    stall    = (load_use || hilo_haz) && !EX_BranchTaken;
  end

  // Flush outranks stall, which outranks normal flow.
  always_comb begin
    nop       = 1'b1;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    if (EX_BranchTaken) begin
      nop       = 1'b0;
      IFIDFlush = 1'b1;
    end else if (stall) begin
      nop       = 1'b0;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end
  end

  // A muldiv only issues when its control actually passes into ID/EX.
  assign issue = ID_MulDiv && nop;

  hilo_busy_counter #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_hilo_busy_counter (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .load (issue),
    .busy (HiLoBusy)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount <= '0;
    end else if (stall && (StallCount != '1)) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller that produces the bubble/stall controls consumed by the ID/EX control-zeroing mux, the PC register and the IF/ID register. It detects load-use hazards, tracks in-flight multi-cycle Hi/Lo (mult/div/madd) operations with a busy counter, and converts a taken branch into an IF/ID flush plus a bubble. It sits in the ID stage beside the control unit and drives the control mux's `nop` select, where `nop`=1 passes control and `nop`=0 inserts a bubble.

## Interface
- MULDIV_CYCLES, 4, Hi/Lo result latency in cycles after issue; legal range 1..15.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports (direction, width, meaning):
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  destination register of the instruction in EX.
- IFID_Rs  in  5  source register rs of the instruction in ID.
- IFID_Rt  in  5  source register rt of the instruction in ID.
- IFID_UsesRt  in  1  instruction in ID reads rt.
- ID_MulDiv  in  1  instruction in ID writes Hi/Lo over multiple cycles.
- ID_ReadsHiLo  in  1  instruction in ID reads Hi/Lo (mfhi, mflo, madd, msub).
- EX_BranchTaken  in  1  branch or jump resolved taken in EX this cycle.
- nop  out  1  1 = pass ID control into ID/EX; 0 = bubble.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  clear IF/ID on the next edge.
- HiLoBusy  out  1  Hi/Lo operation still in flight.
- StallCount  out  STALL_CNT_W  saturating count of stall cycles since reset.

## Operation
- load_use = IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt))).
- hilo_haz = (ID_MulDiv | ID_ReadsHiLo) & HiLoBusy.
- stall = (load_use | hilo_haz) & ~EX_BranchTaken.
- Output priority is flush, then stall, then normal.
  - Flush (EX_BranchTaken=1): nop=0, IFIDFlush=1, PCWrite=1, IFIDWrite=1.
  - Stall: nop=0, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
  - Normal: nop=1, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- A load-use stall and a Hi/Lo stall in the same cycle produce a single stall cycle (the same outputs); neither hazard is queued.
- State machine (two states):
  - IDLE: if an issue occurs (ID_MulDiv & nop=1), load the counter with MULDIV_CYCLES and go to BUSY. Otherwise stay in IDLE.
  - BUSY: decrement the counter every cycle. When counter == 1, go to IDLE with counter = 0.
- HiLoBusy = (state == BUSY).
- A muldiv cannot issue while in BUSY, because hilo_haz stalls it.
- A flush never issues the flushed muldiv: no counter load. A flush does not cancel a counter that is already running.
- StallCount increments on each cycle where stall=1 and holds at all-ones; flush cycles are not counted.

## Timing
- nop, PCWrite, IFIDWrite and IFIDFlush are combinational from inputs and state, with zero latency.
- Issue on edge t makes HiLoBusy=1 for exactly MULDIV_CYCLES cycles after t. A dependent instruction is stalled in each of those cycles and passes in the first cycle after them.
- With MULDIV_CYCLES=1: one BUSY cycle, then IDLE.
- Reset values (Rst_n=0, asynchronous): state=IDLE, counter=0, StallCount=0, HiLoBusy=0.
- Reset values with all inputs idle: nop=1, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- Reset asserted mid-BUSY returns the unit to IDLE immediately, with no residual stall.

## Structure
- Shared package mips_pipe_pkg holds:
  - the hz_state_t enum {HZ_IDLE, HZ_BUSY};
  - the REG_ZERO constant (5'd0).
- Sub-module hilo_busy_counter (load, decrement, busy flag, parameter MULDIV_CYCLES) contains the BUSY FSM and counter.
- The top level holds the hazard compare logic, output priority and StallCount.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> one cycle of nop=0, PCWrite=0, IFIDWrite=0. The next cycle, with IDEX_MemRead=0, returns to nop=1.
- Load into $0: IDEX_Rt=0, IFID_Rs=0, IDEX_MemRead=1 -> no stall, nop=1.
- Muldiv issue then mflo in ID (MULDIV_CYCLES=4) -> HiLoBusy=1 for 4 cycles; stall for 4 cycles; mflo passes in cycle 5; StallCount=4.
- Branch taken during a load-use stall -> IFIDFlush=1, PCWrite=1, nop=0, and StallCount unchanged.
- Branch taken with ID_MulDiv=1 in IDLE -> counter not loaded, HiLoBusy stays 0.
- Rst_n pulsed low at BUSY counter=2 -> HiLoBusy=0 immediately and StallCount=0. Preload StallCount to all-ones minus 1, then hold a stall for 3 cycles -> StallCount saturates at all-ones.
